// File: rtl/vga_rtc_pkg.sv
// Shared definitions for the VGA time/date register bank: arbitration states,
// control-port bit layout and default sizing.
package vga_rtc_pkg;

  typedef enum logic [1:0] {
    ST_RTC    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam int CTRL_EDIT_BIT = 7;
  localparam int CTRL_IDX_MSB  = 3;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_REGS  = 9;

endpackage

// File: rtl/vga_dirty_scan.sv
// Lowest-set-bit priority encoder over the dirty mask; picks the next register
// to stream back to the RTC writer.
module vga_dirty_scan
  import vga_rtc_pkg::*;
#(
  parameter int  N = DEF_NUM_REGS,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic         any_set
);

  // Scan from the top down so the lowest set bit is the last one kept.
  always_comb begin
    idx     = {W{1'b0}};
    any_set = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx     = mask[i] ? W'(i) : idx;
      any_set = any_set | mask[i];
    end
  end

endmodule

// File: rtl/vga_reg_bank_arb.sv
// Display register bank shared by the RTC reader and the PicoBlaze editor, with
// dirty-word write-back to the RTC. Optional macro SHADOW_FRAME_EN selects a
// frame-synchronous shadow copy for data_vga.
module vga_reg_bank_arb
  import vga_rtc_pkg::*;
#(
  parameter int         DATA_W    = DEF_DATA_W,
  parameter int         NUM_REGS  = DEF_NUM_REGS,
  parameter logic [7:0] PORT_BASE = 8'h00,
  localparam int        IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pb_write_strobe,
  input  logic [7:0]                 pb_port_id,
  input  logic [DATA_W-1:0]          pb_data,
  input  logic [NUM_REGS-1:0]        rtc_en,
  input  logic [DATA_W-1:0]          rtc_data,
  input  logic                       frame_start,
  input  logic                       commit_ready,
  output logic                       commit_valid,
  output logic [IDX_W-1:0]           commit_addr,
  output logic [DATA_W-1:0]          commit_data,
  output logic [NUM_REGS*DATA_W-1:0] data_vga,
  output logic [NUM_REGS-1:0]        pointer,
  output logic                       edit_mode,
  output logic                       busy
);

  localparam logic [8:0] CTRL_PORT = {1'b0, PORT_BASE} + 9'(NUM_REGS);

  state_e                     state_r, state_nxt_s;
  logic [DATA_W-1:0]          regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]        dirty_r, dirty_nxt_s;
  logic [3:0]                 idx_r, idx_nxt_s;
  logic [8:0]                 port_off_s;
  logic                       ctrl_wr_s, ctrl_edit_s, data_hit_s;
  logic [3:0]                 ctrl_idx_s;
  logic [NUM_REGS-1:0]        rtc_we_s, pb_we_s, clr_s, pointer_nxt_s;
  logic [IDX_W-1:0]           scan_idx_s, commit_addr_nxt_s;
  logic                       scan_any_s, commit_valid_nxt_s;
  logic [DATA_W-1:0]          commit_data_nxt_s;
  logic [NUM_REGS*DATA_W-1:0] bank_flat_s;
  logic                       commit_valid_r;
  logic [IDX_W-1:0]           commit_addr_r;
  logic [DATA_W-1:0]          commit_data_r;
  logic [NUM_REGS-1:0]        pointer_r;
  logic                       edit_mode_r, busy_r;

  // A port below PORT_BASE wraps to >= 257 in 9 bits, so one compare bounds both sides.
  assign port_off_s  = {1'b0, pb_port_id} - {1'b0, PORT_BASE};
  assign ctrl_wr_s   = pb_write_strobe & ({1'b0, pb_port_id} == CTRL_PORT);
  assign data_hit_s  = pb_write_strobe & (port_off_s < 9'(NUM_REGS));
  assign ctrl_edit_s = pb_data[CTRL_EDIT_BIT];
  assign ctrl_idx_s  = pb_data[CTRL_IDX_MSB:0];

  // Per-register write enables; each source is only honoured in its owning state.
  always_comb begin
    rtc_we_s = {NUM_REGS{1'b0}};
    pb_we_s  = {NUM_REGS{1'b0}};
    clr_s    = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rtc_we_s[i] = (state_r == ST_RTC) & rtc_en[i];
      pb_we_s[i]  = (state_r == ST_EDIT) & data_hit_s & (port_off_s == 9'(i));
      clr_s[i]    = commit_valid_r & commit_ready & (commit_addr_r == IDX_W'(i));
    end
  end

  // Live register bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rtc_we_s[i])     regs_r[i] <= rtc_data;
        else if (pb_we_s[i]) regs_r[i] <= pb_data;
        else                 regs_r[i] <= regs_r[i];
      end
    end
  end

  // Flatten the bank into the display bus layout.
  always_comb begin
    bank_flat_s = {(NUM_REGS*DATA_W){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) bank_flat_s[i*DATA_W +: DATA_W] = regs_r[i];
  end

  // Ownership FSM, dirty tracking and cursor index.
  always_comb begin
    state_nxt_s = state_r;
    dirty_nxt_s = dirty_r;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_RTC: begin
        state_nxt_s = (ctrl_wr_s & ctrl_edit_s) ? ST_EDIT : ST_RTC;
        dirty_nxt_s = (ctrl_wr_s & ctrl_edit_s) ? {NUM_REGS{1'b0}} : dirty_r;
        idx_nxt_s   = (ctrl_wr_s & ctrl_edit_s) ? ctrl_idx_s : idx_r;
      end
      ST_EDIT: begin
        dirty_nxt_s = dirty_r | pb_we_s;
        if (ctrl_wr_s & ctrl_edit_s) begin
          state_nxt_s = ST_EDIT;
          idx_nxt_s   = ctrl_idx_s;
        end else if (ctrl_wr_s) begin
          state_nxt_s = (|dirty_r) ? ST_COMMIT : ST_RTC;
          idx_nxt_s   = idx_r;
        end else begin
          state_nxt_s = ST_EDIT;
          idx_nxt_s   = idx_r;
        end
      end
      ST_COMMIT: begin
        dirty_nxt_s = dirty_r & ~clr_s;
        state_nxt_s = (|(dirty_r & ~clr_s)) ? ST_COMMIT : ST_RTC;
      end
      default: begin
        state_nxt_s = ST_RTC;
        dirty_nxt_s = {NUM_REGS{1'b0}};
        idx_nxt_s   = 4'd0;
      end
    endcase
  end

  vga_dirty_scan #(
    .N (NUM_REGS)
  ) u_scan (
    .mask    (dirty_nxt_s),
    .idx     (scan_idx_s),
    .any_set (scan_any_s)
  );

  // Next commit word comes from the post-handshake mask so transfers run back to back.
  always_comb begin
    commit_valid_nxt_s = (state_nxt_s == ST_COMMIT) & scan_any_s;
    commit_addr_nxt_s  = commit_valid_nxt_s ? scan_idx_s : {IDX_W{1'b0}};
    commit_data_nxt_s  = commit_valid_nxt_s ? regs_r[scan_idx_s] : {DATA_W{1'b0}};
    pointer_nxt_s      = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      pointer_nxt_s[i] = (state_nxt_s == ST_EDIT) & (idx_nxt_s == 4'(i));
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_RTC;
      dirty_r        <= {NUM_REGS{1'b0}};
      idx_r          <= 4'd0;
      commit_valid_r <= 1'b0;
      commit_addr_r  <= {IDX_W{1'b0}};
      commit_data_r  <= {DATA_W{1'b0}};
      pointer_r      <= {NUM_REGS{1'b0}};
      edit_mode_r    <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      dirty_r        <= dirty_nxt_s;
      idx_r          <= idx_nxt_s;
      commit_valid_r <= commit_valid_nxt_s;
      commit_addr_r  <= commit_addr_nxt_s;
      commit_data_r  <= commit_data_nxt_s;
      pointer_r      <= pointer_nxt_s;
      edit_mode_r    <= (state_nxt_s == ST_EDIT);
      busy_r         <= (state_nxt_s == ST_COMMIT);
    end
  end

  assign commit_valid = commit_valid_r;
  assign commit_addr  = commit_addr_r;
  assign commit_data  = commit_data_r;
  assign pointer      = pointer_r;
  assign edit_mode    = edit_mode_r;
  assign busy         = busy_r;

`ifdef SHADOW_FRAME_EN
  logic [NUM_REGS*DATA_W-1:0] shadow_r;

  // Snapshot the live bank once per frame for tear-free display.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           shadow_r <= {(NUM_REGS*DATA_W){1'b0}};
    else if (frame_start) shadow_r <= bank_flat_s;
    else                  shadow_r <= shadow_r;
  end

  assign data_vga = shadow_r;
`else
  logic unused_frame_s;

  assign unused_frame_s = frame_start;
  assign data_vga       = bank_flat_s;
`endif

endmodule

// File: doc/vga_reg_bank_arb.md
Name: vga_reg_bank_arb

Overview:
Parametrised display-data register bank for the VGA text path. It owns NUM_REGS registers of DATA_W bits shown on screen (time/date fields) and arbitrates write ownership between the RTC reader and the PicoBlaze editor. On leaving edit mode it streams every PicoBlaze-modified register back to the RTC writer over a valid/ready handshake. It also drives the one-hot edit pointer used for cursor highlighting, and sits between the PicoBlaze/RTC ports and the VGA text generator.

Parameters:
DATA_W, 8, register width in bits
NUM_REGS, 9, number of display registers (2..16)
PORT_BASE, 8'h00, PicoBlaze port_id of register 0; registers occupy PORT_BASE..PORT_BASE+NUM_REGS-1; control port is PORT_BASE+NUM_REGS
IDX_W, $clog2(NUM_REGS), localparam, register index width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pb_write_strobe  in  1  PicoBlaze write strobe, one cycle
pb_port_id  in  8  PicoBlaze port address
pb_data  in  DATA_W  PicoBlaze write data
rtc_en  in  NUM_REGS  per-register load enables from RTC reader
rtc_data  in  DATA_W  RTC read data
frame_start  in  1  one-cycle pulse at start of vertical blank
commit_ready  in  1  RTC writer accepts current commit word
commit_valid  out  1  commit word available
commit_addr  out  IDX_W  register index being committed
commit_data  out  DATA_W  register value being committed
data_vga  out  NUM_REGS*DATA_W  display data; register i at [i*DATA_W +: DATA_W]
pointer  out  NUM_REGS  one-hot edit cursor; all zero outside EDIT
edit_mode  out  1  high in EDIT
busy  out  1  high in COMMIT

Behaviour:
- States: RTC (reset state), EDIT, COMMIT.
- Reset (reset=0, async): all registers 0, dirty mask 0, pointer index 0, state RTC; data_vga 0, pointer 0, edit_mode 0, busy 0, commit_valid 0, commit_addr 0, commit_data 0.
- Control write (strobe & port_id==PORT_BASE+NUM_REGS): bit7=edit, bits[3:0]=pointer index.
  - RTC, edit=1 -> EDIT, dirty mask cleared, index latched.
  - EDIT, edit=1 -> index updated only.
  - EDIT, edit=0 -> COMMIT if dirty≠0, else RTC.
  - Any other combination ignored; control writes are ignored in COMMIT.
- RTC state: register i loads rtc_data in any cycle rtc_en[i]=1; several bits set load all selected registers. PicoBlaze data writes are ignored.
- EDIT: strobe & port_id==PORT_BASE+i (i<NUM_REGS) loads pb_data into register i and sets dirty[i]. rtc_en is ignored (no queuing).
- COMMIT: register bank frozen; both PB and RTC writes ignored. commit_valid=1, commit_addr=lowest set dirty bit, commit_data=that register (registered outputs, first word valid the cycle after entry). Addr/data are held stable while valid & !ready. On valid & ready, that dirty bit is cleared and the next-lowest word is presented the next cycle, so back-to-back transfers run at 1 word/cycle. After the last handshake: commit_valid=0 and state RTC.
- Write latency: register update is visible on the live bank one cycle after the strobe/enable.
- pointer: one-hot of latched index in EDIT; index ≥ NUM_REGS gives all zeros.
- Port ids outside the decoded range are ignored.
- Async reset during COMMIT aborts the stream immediately; remaining dirty data is discarded.

Optional Feature:
SHADOW_FRAME_EN: defined -> data_vga driven from a shadow copy that loads the whole live bank on frame_start, giving tear-free display with 0–1 frame latency; the shadow resets to 0. Undefined -> data_vga is the live bank directly, and frame_start is unused.

Decomposition:
- Shared package vga_rtc_pkg: state encoding (ST_RTC, ST_EDIT, ST_COMMIT), control-port bit positions (CTRL_EDIT_BIT=7, CTRL_IDX_MSB=3), default DATA_W/NUM_REGS.
- One natural sub-module: vga_dirty_scan, a combinational lowest-set-bit priority encoder over the dirty mask (outputs index + any_set), reused for commit sequencing.

Test Plan:
- Reset then rtc_en=9'h001, rtc_data=8'h45 -> data_vga[7:0]=8'h45 next cycle; pointer=0, edit_mode=0.
- Write 8'h82 to port 0x09 -> edit_mode=1, pointer=9'b000000100; rtc_en=9'h004, rtc_data=8'h11 during EDIT -> register 2 unchanged.
- In EDIT: write 8'h30 to port 0x05 and 8'h12 to port 0x01, then write 8'h00 to port 0x09 with commit_ready=1 -> busy=1; words (addr1,12) then (addr5,30) on consecutive cycles; then state RTC, commit_valid=0.
- Same edits with commit_ready held 0 for 4 cycles -> addr1/data 12 stable for all 4 cycles; completes normally once ready=1.
- EDIT with no data writes, then exit -> direct to RTC, commit_valid never asserted; control write 8'h8F (index 15) -> pointer=0.
- Assert reset low mid-COMMIT -> all outputs 0 immediately. With SHADOW_FRAME_EN defined, an RTC write changes data_vga only after the next frame_start pulse.
